// File: rtl/mmio_console_tx.sv
// Memory-mapped console: TX FIFO feeding an 8N1 UART, a sticky finish latch and a status register.
// Claims every address with bit 31 set; bits [3:2] select TXDATA, STATUS, FINI or reserved.
module mmio_console_tx #(
   parameter int unsigned CLKS_PER_BIT = 100,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter logic [31:0] FINI_CODE    = 32'h00020000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] dbus_addr_i,
   input  logic        dbus_wvalid_i,
   input  logic [31:0] dbus_wdata_i,
   output logic        dbus_wready_o,
   input  logic        dbus_rvalid_i,
   output logic [31:0] dbus_rdata_o,
   output logic        dbus_rdvalid_o,
   output logic        txd_o,
   output logic        fini_o,
   output logic        fini_err_o
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW = AW + 1;
   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state;
   logic [CW-1:0]   baud;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CNTW-1:0] count;
   logic            ovf;

   logic        sel;
   logic [1:0]  off;
   logic        full, empty, tx_busy, baud_end;
   logic        wr_txdata, wr_fini, rd_sel, rd_status, push, pop;
   logic [31:0] status_word;
   logic        unused_addr;

   assign sel         = dbus_addr_i[31];
   assign off         = dbus_addr_i[3:2];
   assign unused_addr = ^{dbus_addr_i[30:4], dbus_addr_i[1:0]};

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign tx_busy   = (state != IDLE);
   assign baud_end  = (baud == BAUD_LAST);

   assign wr_txdata = sel && dbus_wvalid_i && (off == 2'd0);
   assign wr_fini   = sel && dbus_wvalid_i && (off == 2'd2);
   assign rd_sel    = sel && dbus_rvalid_i;
   assign rd_status = rd_sel && (off == 2'd1);
   // Full is judged before this cycle's pop, so a push at full is refused even while draining.
   assign push      = wr_txdata && !full;
   assign pop       = (state == IDLE) && !empty;

   assign status_word = {fini_o, 15'd0, 8'(count), 4'd0, ovf, empty, full, tx_busy};

   always_comb begin
      dbus_wready_o = 1'b0;
      if (sel) dbus_wready_o = (off == 2'd0) ? !full : 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= dbus_wdata_i[7:0];
      if (pop)  shreg       <= mem[rd_ptr];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: ;
         endcase
      end
   end

   // Bus side: reads see pre-write state; an overflow in the same cycle as a STATUS read survives.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dbus_rdvalid_o <= 1'b0;
         dbus_rdata_o   <= '0;
         ovf            <= 1'b0;
         fini_o         <= 1'b0;
         fini_err_o     <= 1'b0;
      end else begin
         dbus_rdvalid_o <= rd_sel;
         if (rd_sel) dbus_rdata_o <= (off == 2'd1) ? status_word : 32'd0;
         if (wr_txdata && full) ovf <= 1'b1;
         else if (rd_status)    ovf <= 1'b0;
         if (wr_fini) begin
            if (dbus_wdata_i == FINI_CODE) fini_o     <= 1'b1;
            else                           fini_err_o <= 1'b1;
         end
      end
   end

   // UART framer: txd_o is registered so each level appears the cycle the state is entered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         txd_o   <= 1'b1;
      end else begin
         baud <= baud_end ? '0 : baud + CW'(1);
         case (state)
            IDLE: begin
               txd_o <= 1'b1;
               baud  <= '0;
               if (!empty) begin
                  state <= START;
                  txd_o <= 1'b0;
               end
            end
            START: if (baud_end) begin
               state   <= DATA;
               bit_idx <= 3'd0;
               txd_o   <= shreg[0];
            end
            DATA: if (baud_end) begin
               bit_idx <= bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state <= STOP;
                  txd_o <= 1'b1;
               end else begin
                  txd_o <= shreg[bit_idx + 3'd1];
               end
            end
            STOP: if (baud_end) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_console_tx.sv
// Randomised bench for mmio_console_tx: a queue-based console model predicts bus reads and UART
// bytes; independent monitors decode the serial line and the read channel and compare.
module tb_mmio_console_tx;

   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] FCODE = 32'h00020000;
   localparam logic [31:0] A_TX  = 32'h80000000;
   localparam logic [31:0] A_ST  = 32'h80000004;
   localparam logic [31:0] A_FI  = 32'h80000008;
   localparam logic [31:0] A_RS  = 32'h8000000C;
   localparam logic [31:0] A_LO  = 32'h00001000;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [31:0] dbus_addr_i;
   logic        dbus_wvalid_i;
   logic [31:0] dbus_wdata_i;
   logic        dbus_wready_o;
   logic        dbus_rvalid_i;
   logic [31:0] dbus_rdata_o;
   logic        dbus_rdvalid_o;
   logic        txd_o;
   logic        fini_o;
   logic        fini_err_o;

   mmio_console_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FINI_CODE(FCODE)) dut (
      .clk_i(clk), .rst_i(rst_i), .dbus_addr_i(dbus_addr_i), .dbus_wvalid_i(dbus_wvalid_i),
      .dbus_wdata_i(dbus_wdata_i), .dbus_wready_o(dbus_wready_o), .dbus_rvalid_i(dbus_rvalid_i),
      .dbus_rdata_o(dbus_rdata_o), .dbus_rdvalid_o(dbus_rdvalid_o), .txd_o(txd_o),
      .fini_o(fini_o), .fini_err_o(fini_err_o));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: bytes waiting, the cycle the current frame ends, sticky flags, expected outputs.
   int          t        = 0;
   int          busy_end = -1;
   logic [7:0]  mq[$];
   logic [7:0]  uart_exp[$];
   logic [31:0] rd_exp[$];
   bit          m_ovf = 0, m_fini = 0, m_err = 0;
   int          rst_count = 0;
   bit          started = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, t);
      end
   endtask

   // One bus cycle: drive at the falling edge, predict, then wait for the next falling edge.
   task automatic step(input bit r, input bit wv, input bit rv, input logic [31:0] addr,
                       input logic [31:0] wd);
      bit   busy, full, empty, pop, wr_tx, st_rd;
      logic ew;
      int   n;
      if (started) begin
         check("fini", fini_o, m_fini);
         check("fini_err", fini_err_o, m_err);
      end
      rst_i = r; dbus_wvalid_i = wv; dbus_rvalid_i = rv; dbus_addr_i = addr; dbus_wdata_i = wd;
      if (r) rst_count++;
      #1;
      n     = mq.size();
      full  = (n == DEPTH);
      empty = (n == 0);
      busy  = (t <= busy_end);
      ew    = addr[31] ? ((addr[3:2] == 2'd0) ? !full : 1'b1) : 1'b0;
      if (wv && !r) check("wready", dbus_wready_o, ew);
      if (r) begin
         mq.delete(); uart_exp.delete();
         busy_end = -1; m_ovf = 0; m_fini = 0; m_err = 0;
      end else begin
         st_rd = rv && addr[31] && (addr[3:2] == 2'd1);
         if (rv && addr[31])
            rd_exp.push_back(st_rd ? {m_fini, 15'd0, 8'(n), 4'd0, m_ovf, empty, full, busy} : 32'd0);
         pop   = !busy && !empty;
         wr_tx = wv && addr[31] && (addr[3:2] == 2'd0);
         if (pop) begin
            uart_exp.push_back(mq.pop_front());
            busy_end = t + 10 * CPB;
         end
         if (wr_tx && !full) mq.push_back(wd[7:0]);
         if (wr_tx && full) m_ovf = 1;
         else if (st_rd)    m_ovf = 0;
         if (wv && addr[31] && (addr[3:2] == 2'd2)) begin
            if (wd == FCODE) m_fini = 1;
            else             m_err  = 1;
         end
      end
      t++;
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, 32'd0, 32'd0);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 32'd0, 32'd0);
      step(1, 0, 0, 32'd0, 32'd0);
   endtask

   task automatic drain(input int limit);
      int k = 0;
      while ((mq.size() != 0 || t <= busy_end || uart_exp.size() != 0) && k < limit) begin
         idle();
         k++;
      end
      check("drain_in_time", (k < limit), 1);
      repeat (3) idle();
   endtask

   // Serial monitor: find a start bit, sample each bit near its middle, compare the byte.
   initial begin : uart_mon
      forever begin
         @(negedge clk);
         if (txd_o === 1'b0) begin
            int         rc;
            logic [7:0] b;
            logic       st, sb;
            rc = rst_count;
            repeat (CPB / 2) @(negedge clk);
            st = txd_o;
            for (int k = 0; k < 8; k++) begin
               repeat (CPB) @(negedge clk);
               b[k] = txd_o;
            end
            repeat (CPB) @(negedge clk);
            sb = txd_o;
            if (rc == rst_count) begin
               check("uart_start", st, 0);
               check("uart_stop", sb, 1);
               if (uart_exp.size() == 0) begin
                  total++; bad++;
                  $display("FAIL uart_extra: got byte %h want none", b);
               end else begin
                  check("uart_byte", b, uart_exp.pop_front());
               end
            end
         end
      end
   end

   initial begin : read_mon
      forever begin
         @(negedge clk);
         if (dbus_rdvalid_o === 1'b1) begin
            if (rd_exp.size() == 0) begin
               total++; bad++;
               $display("FAIL rd_extra: got %h want no read data", dbus_rdata_o);
            end else begin
               check("rdata", dbus_rdata_o, rd_exp.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] b41;
      b41 = 8'h41;
      do_reset();
      started = 1;

      // Reset state and an idle STATUS read.
      check("txd_reset", txd_o, 1);
      check("rdvalid_reset", dbus_rdvalid_o, 0);
      step(0, 0, 1, A_ST, 32'd0);
      check("status_reset", dbus_rdata_o, 32'h4);
      repeat (3) idle();
      check("rdata_hold", dbus_rdata_o, 32'h4);

      // Single frame waveform with STATUS reads straddling the end of tx_busy.
      step(0, 1, 0, A_TX, 32'h41);
      for (int i = 1; i <= 44; i++) begin
         logic e;
         if (i < 2)                e = 1'b1;
         else if (i < 2 + CPB)     e = 1'b0;
         else if (i < 2 + 9 * CPB) e = b41[3'((i - 2 - CPB) / CPB)];
         else                      e = 1'b1;
         check("txd_wave", txd_o, e);
         if (i == 41 || i == 42) step(0, 0, 1, A_ST, 32'd0);
         else                    idle();
      end

      // Overflow: keep the UART busy, then push five bytes into a four-deep FIFO.
      step(0, 1, 0, A_TX, 32'h55);
      idle();
      for (int i = 0; i < 5; i++) step(0, 1, 0, A_TX, 32'h30 + i);
      step(0, 0, 1, A_ST, 32'd0);
      step(0, 0, 1, A_ST, 32'd0);
      drain(1000);

      // Finish codes.
      step(0, 1, 0, A_FI, FCODE);
      check("fini_set", fini_o, 1);
      step(0, 0, 1, A_ST, 32'd0);
      idle();
      do_reset();
      step(0, 1, 0, A_FI, 32'h1);
      check("fini_err_set", fini_err_o, 1);
      check("fini_clear", fini_o, 0);
      idle();

      // Reset in the middle of data bit 3 with two bytes queued.
      do_reset();
      step(0, 1, 0, A_TX, 32'hA5);
      step(0, 1, 0, A_TX, 32'h11);
      step(0, 1, 0, A_TX, 32'h22);
      repeat (16) idle();
      step(1, 0, 0, 32'd0, 32'd0);
      check("txd_abort", txd_o, 1);
      step(0, 0, 1, A_ST, 32'd0);
      repeat (80) idle();

      // Unselected window and reserved offset.
      step(0, 1, 0, A_LO, 32'h77);
      step(0, 0, 1, A_LO, 32'd0);
      step(0, 1, 1, A_RS, 32'h99);
      step(0, 0, 1, A_ST, 32'd0);
      repeat (3) idle();

      // Random traffic in phases of heavy and light TXDATA writes.
      for (int i = 0; i < 1600; i++) begin
         int          kind, wprob;
         logic [31:0] a, d;
         bit          wv, rv;
         wprob = ((i / 200) % 2 == 0) ? 40 : 3;
         kind  = $urandom_range(0, 9);
         d     = $urandom();
         if (kind <= 5)      a = {1'b1, 27'($urandom()), 2'd0, 2'($urandom())};
         else if (kind <= 7) a = {1'b1, 27'($urandom()), 2'd1, 2'($urandom())};
         else if (kind == 8) a = {1'b1, 27'($urandom()), 2'($urandom_range(2, 3)), 2'($urandom())};
         else                a = $urandom() & 32'h7FFFFFFF;
         if (a[31] && a[3:2] == 2'd2 && $urandom_range(0, 1) == 1) d = FCODE;
         wv = ($urandom_range(0, 99) < wprob) || (a[3:2] != 2'd0 && $urandom_range(0, 9) == 0);
         rv = ($urandom_range(0, 3) == 0);
         step(0, wv, rv, a, d);
      end
      drain(5000);
      check("rd_pending", rd_exp.size(), 0);
      check("uart_pending", uart_exp.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_console_tx.md
Name: mmio_console_tx

Overview:
- Synthesizable memory-mapped console responder on the core data bus.
- Claims the MMIO window where dbus_addr_i[31] is 1.
- Accepts character writes into a TX FIFO and serializes them on an 8N1 UART line.
- Latches the simulation/program finish code, and exposes a status register for CPU reads. This is the hardware-side counterpart of the bench console/finish monitor, so FPGA builds report output and finish without a simulator.

Parameters:
- CLKS_PER_BIT, 100, clk_i cycles per UART bit; must be ≥2.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- FINI_CODE, 32'h00020000, write value that sets fini_o.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- dbus_addr_i  in  32  bus address; selected when bit31=1; register offset is bits[3:2]
- dbus_wvalid_i  in  1  write request
- dbus_wdata_i  in  32  write data
- dbus_wready_o  out  1  write accepted this cycle (combinational)
- dbus_rvalid_i  in  1  read request
- dbus_rdata_o  out  32  read data
- dbus_rdvalid_o  out  1  read data valid, one cycle after request
- txd_o  out  1  UART serial output, idle high
- fini_o  out  1  sticky finish flag
- fini_err_o  out  1  finish written with wrong code to the FINI register

Behaviour:
- Reset values: txd_o=1, fini_o=0, fini_err_o=0, dbus_rdvalid_o=0, dbus_rdata_o=0. FIFO is empty, ovf=0, FSM is IDLE.
- Mid-operation reset aborts any frame in progress: txd_o returns to 1 the next cycle and FIFO contents are discarded.
- Register map (offset = addr[3:2], only when addr[31]=1):
  - 0 TXDATA (W): push wdata[7:0].
  - 1 STATUS (R): bit0 tx_busy, bit1 full, bit2 empty, bit3 ovf (sticky), bits[15:8] FIFO count, bit31 fini_o; other bits read 0.
  - 2 FINI (W): if wdata==FINI_CODE set fini_o, else set fini_err_o.
  - 3: reserved; writes are ignored, reads return 0.
- dbus_wready_o behaviour:
  - Equals !full for a TXDATA write.
  - Equals 1 for every other selected offset.
  - Equals 0 when addr[31]=0 (not selected).
- TXDATA write while full: not accepted, byte dropped, ovf set. The initiator is expected to poll STATUS.
- Push and pop in the same cycle when not full: both happen and the count is unchanged.
- Full is evaluated before the pop, so a push at full is rejected even if a pop occurs that cycle.
- Reads:
  - A selected dbus_rvalid_i in cycle N gives dbus_rdvalid_o=1 and dbus_rdata_o valid in cycle N+1, for exactly 1 cycle.
  - dbus_rdata_o holds its value after that cycle.
  - A STATUS read returns the pre-clear ovf value, and ovf clears at the same edge.
  - A read and write in the same cycle are both serviced; the read sees pre-write state.
- fini_o and fini_err_o are sticky until rst_i.
- A FINI write does not wait for the FIFO to drain; software polls STATUS.empty and tx_busy before finishing.
- UART FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: txd_o=1. If the FIFO is not empty, pop the head into the shift register and go to START the next cycle.
  - START: txd_o=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; a 3-bit index wraps 7→0 and exits to STOP.
  - STOP: txd_o=1 for CLKS_PER_BIT cycles, then IDLE. Back-to-back frames therefore have 1 extra idle cycle between them.
  - tx_busy=1 in START, DATA and STOP.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps; it is cleared on every state entry.
- FIFO: wrap-around pointers of log2(FIFO_DEPTH) bits plus count of log2(FIFO_DEPTH)+1 bits. Count is reported zero-extended/truncated to 8 bits.

Test Plan:
- Reset, CLKS_PER_BIT=4 → after reset: txd_o=1, STATUS read = 0x00000004 (empty), fini_o=0.
- Write 0x41 to 0x80000000 at cycle 0 → txd_o goes low at cycle 2 for 4 cycles, then 1,0,0,0,0,0,1,0 (LSB first, 4 cycles each), then high for 4 cycles; tx_busy falls after 40 cycles of frame.
- FIFO_DEPTH=4: 5 back-to-back TXDATA writes 0x30..0x34 with UART busy → the 5th sees wready=0. Next STATUS read shows bit3=1 and count per the drain; the following read shows bit3=0. txd_o emits 0x30..0x33 only.
- Write 0x00020000 to 0x80000008 → fini_o=1 next cycle, STATUS bit31=1. Write 0x1 to FINI on a fresh reset → fini_err_o=1, fini_o=0.
- Assert rst_i mid-DATA bit 3 of a frame with 2 bytes queued → txd_o=1 next cycle, STATUS = 0x00000004, no further frames.
- Write with addr[31]=0 (0x00001000) → wready=0, no push; read with addr[31]=0 → dbus_rdvalid_o stays 0.
